// File: rtl/h2f_bridge_pkg.sv
// Shared types and default sizes for the HPS-to-FPGA register bridge and its fabric-side arbiter.
package h2f_bridge_pkg;

    localparam int unsigned DEF_TOTREG    = 32;
    localparam int unsigned DEF_DATAWIDTH = 32;
    localparam int unsigned DEF_SEL_W     = $clog2(DEF_TOTREG);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StAck
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin select: first request strictly after ptr, wrapping, gives one-hot and id.
module rr_arbiter_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   id,
    output logic            valid
);

    logic [NREQ-1:0] above;
    logic [NREQ-1:0] pool;

    always_comb begin
        above = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            above[i] = (i > 32'(ptr)) & req[i];
        end
        // Fall back to the full vector once nothing above the pointer remains (wrap).
        pool  = (|above) ? above : req;
        gnt   = '0;
        id    = '0;
        valid = |req;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pool[i] && (gnt == '0)) begin
                gnt[i] = 1'b1;
                id     = IW'(i);
            end
        end
    end

endmodule

// File: rtl/h2f_fabric_reg_arbiter.sv
// Round-robin arbiter sharing the fabric register port of the HPS-to-FPGA bank among NREQ
// requesters; fabric writes stall behind HPS writes and abort after TIMEOUT stall cycles.
module h2f_fabric_reg_arbiter
    import h2f_bridge_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned TOTREG    = DEF_TOTREG,
    parameter int unsigned DATAWIDTH = DEF_DATAWIDTH,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req_i,
    input  logic [NREQ-1:0]                   req_we_i,
    input  logic [NREQ*$clog2(TOTREG)-1:0]    req_sel_i,
    input  logic [NREQ*DATAWIDTH-1:0]         req_wdata_i,
    output logic [NREQ-1:0]                   ack_o,
    output logic                              err_o,
    output logic [DATAWIDTH-1:0]              rdata_o,
    output logic                              busy_o,
    input  logic                              hps_write_i,
    output logic [$clog2(TOTREG)-1:0]         fabric_regsel_o,
    output logic                              fabric_regwrite_o,
    output logic [DATAWIDTH-1:0]              fabric_regdata_o,
    input  logic [DATAWIDTH-1:0]              fabric_regdata_i
);

    localparam int unsigned SW = $clog2(TOTREG);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e       state_q;
    logic [IW-1:0]    ptr_q;
    logic [NREQ-1:0]  gnt_q;
    logic             we_q;
    logic [SW-1:0]    sel_q;
    logic [DATAWIDTH-1:0] wdata_q;
    logic [CW-1:0]    cnt_q;
    logic [DATAWIDTH-1:0] rdata_q;
    logic             err_q;
    logic [NREQ-1:0]  ack_q;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    gnt_id;
    logic             gnt_valid;

    rr_arbiter_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .gnt   (gnt),
        .id    (gnt_id),
        .valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= IW'(NREQ - 1);
            gnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        gnt_q   <= gnt;
                        ptr_q   <= gnt_id;
                        we_q    <= req_we_i[gnt_id];
                        sel_q   <= req_sel_i[gnt_id*SW +: SW];
                        wdata_q <= req_wdata_i[gnt_id*DATAWIDTH +: DATAWIDTH];
                        cnt_q   <= '0;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (!we_q) begin
                        rdata_q <= fabric_regdata_i;
                        ack_q   <= gnt_q;
                        state_q <= StAck;
                    end else if (!hps_write_i) begin
                        ack_q   <= gnt_q;
                        state_q <= StAck;
                    end else if ((TIMEOUT != 0) && (32'(cnt_q) + 32'd1 == TIMEOUT)) begin
                        // The bank keeps losing to HPS writes: give up without writing.
                        ack_q   <= gnt_q;
                        err_q   <= 1'b1;
                        state_q <= StAck;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StAck:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack_o             = ack_q;
    assign err_o             = err_q;
    assign rdata_o           = rdata_q;
    assign busy_o            = (state_q != StIdle);
    assign fabric_regsel_o   = sel_q;
    assign fabric_regdata_o  = wdata_q;
    // Combinational so a concurrent HPS write suppresses the strobe in the same cycle.
    assign fabric_regwrite_o = we_q & (state_q == StIssue) & ~hps_write_i;

endmodule

// File: tb/tb_h2f_fabric_reg_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a round-robin reference model.
module tb_h2f_fabric_reg_arbiter;

    localparam int NREQ = 4;
    localparam int TOTREG = 32;
    localparam int DW = 32;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    req_we = '0;
    logic [NREQ*SW-1:0] req_sel = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic               hps_write = 1'b0;

    logic [NREQ-1:0] ack, t_ack;
    logic            err, t_err, busy, t_busy, regwrite, t_regwrite;
    logic [DW-1:0]   rdata, t_rdata, regdata, t_regdata, regdata_in, t_regdata_in;
    logic [SW-1:0]   regsel, t_regsel;

    logic [DW-1:0] bank [0:TOTREG-1];
    logic [DW-1:0] ref_bank [0:TOTREG-1];
    logic          poke_en = 1'b0;
    logic [SW-1:0] poke_addr = '0;
    logic [DW-1:0] poke_data = '0;
    bit            hps_hist [0:4095];

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (poke_en) bank[poke_addr] <= poke_data;
        else if (regwrite) bank[regsel] <= regdata;
    end

    assign regdata_in   = bank[regsel];
    assign t_regdata_in = bank[t_regsel];

    h2f_fabric_reg_arbiter #(.NREQ(NREQ), .TOTREG(TOTREG), .DATAWIDTH(DW), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .req_i(req), .req_we_i(req_we), .req_sel_i(req_sel),
        .req_wdata_i(req_wdata), .ack_o(ack), .err_o(err), .rdata_o(rdata), .busy_o(busy),
        .hps_write_i(hps_write), .fabric_regsel_o(regsel), .fabric_regwrite_o(regwrite),
        .fabric_regdata_o(regdata), .fabric_regdata_i(regdata_in)
    );

    h2f_fabric_reg_arbiter #(.NREQ(NREQ), .TOTREG(TOTREG), .DATAWIDTH(DW), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .req_i(req), .req_we_i(req_we), .req_sel_i(req_sel),
        .req_wdata_i(req_wdata), .ack_o(t_ack), .err_o(t_err), .rdata_o(t_rdata),
        .busy_o(t_busy), .hps_write_i(hps_write), .fabric_regsel_o(t_regsel),
        .fabric_regwrite_o(t_regwrite), .fabric_regdata_o(t_regdata),
        .fabric_regdata_i(t_regdata_in)
    );

    task automatic set_req(input int i, input logic we, input logic [SW-1:0] sel,
                           input logic [DW-1:0] wd);
        req[i] = 1'b1;
        req_we[i] = we;
        req_sel[i*SW +: SW] = sel;
        req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        hps_write = 1'b0;
        for (int i = 0; i < TOTREG; i++) begin
            @(negedge clk);
            poke_en = 1'b1;
            poke_addr = SW'(i);
            poke_data = (i == 5) ? 32'hDEADBEEF : $urandom;
            ref_bank[i] = poke_data;
        end
        @(negedge clk);
        poke_en = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_cmp++; if ({regwrite, regsel, regdata} !== '0) begin
            n_fail++; $display("FAIL reset_bankport: got we=%b sel=%h data=%h want all 0", regwrite, regsel, regdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        @(negedge clk);
        set_req(0, 1'b0, 5'd5, 32'h0);
        @(negedge clk); #1;
        n_cmp++; if ({busy, regwrite, ack} !== {1'b1, 1'b0, 4'b0}) begin
            n_fail++; $display("FAIL read_issue: got busy=%b we=%b ack=%b want 1 0 0000", busy, regwrite, ack);
        end
        @(negedge clk); #1;
        n_cmp++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL read_ack: got %b want 0001", ack); end
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h want deadbeef", rdata); end
        n_cmp++; if ({err, regwrite} !== 2'b00) begin n_fail++; $display("FAIL read_err: got err=%b we=%b want 0 0", err, regwrite); end
        req[0] = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        set_req(2, 1'b1, 5'd3, 32'h12345678);
        @(negedge clk); #1;
        n_cmp++; if ({regwrite, regsel, regdata, ack} !== {1'b1, 5'd3, 32'h12345678, 4'b0}) begin
            n_fail++; $display("FAIL write_strobe: got we=%b sel=%h data=%h ack=%b want 1 03 12345678 0000",
                               regwrite, regsel, regdata, ack);
        end
        @(negedge clk); #1;
        n_cmp++; if ({ack, err, regwrite} !== {4'b0100, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL write_ack: got ack=%b err=%b we=%b want 0100 0 0", ack, err, regwrite);
        end
        req[2] = 1'b0;
        ref_bank[3] = 32'h12345678;
        n_cmp++; if (bank[3] !== 32'h12345678) begin n_fail++; $display("FAIL write_bank: got %h want 12345678", bank[3]); end
        @(negedge clk);
        set_req(0, 1'b0, 5'd3, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if ({ack, rdata} !== {4'b0001, 32'h12345678}) begin
            n_fail++; $display("FAIL write_readback: got ack=%b data=%h want 0001 12345678", ack, rdata);
        end
        req[0] = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [SW-1:0] sels [NREQ];
        int t0, k;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            sels[i] = SW'($urandom_range(0, TOTREG - 1));
            set_req(i, 1'b0, sels[i], 32'h0);
        end
        rst = 1'b0;
        t0 = cyc;
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            @(negedge clk); #1;
            if (ack !== 4'b0) begin
                n_cmp++; if (ack !== (4'b1 << (k % NREQ)) || cyc - t0 != 2 + 3 * k) begin
                    n_fail++; $display("FAIL rr_order[%0d]: got ack=%b at +%0d want %b at +%0d",
                                       k, ack, cyc - t0, 4'b1 << (k % NREQ), 2 + 3 * k);
                end
                n_cmp++; if (rdata !== ref_bank[sels[k % NREQ]]) begin
                    n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", k, rdata, ref_bank[sels[k % NREQ]]);
                end
                k++;
            end
        end
        req = '0;
        n_cmp++; if (k != 5) begin n_fail++; $display("FAIL rr_count: got %0d acks want 5", k); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_hps_collision();
        logic [DW-1:0] wd;
        int pulses;
        wd = $urandom;
        pulses = 0;
        @(negedge clk);
        set_req(1, 1'b1, 5'd7, wd);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            hps_write = (c <= 6);
            #1;
            if (regwrite) pulses++;
            if (c <= 6) begin
                n_cmp++; if ({regwrite, ack} !== 5'b0) begin
                    n_fail++; $display("FAIL hps_stall[%0d]: got we=%b ack=%b want 0 0000", c, regwrite, ack);
                end
            end else if (c == 7) begin
                n_cmp++; if ({regwrite, regsel, regdata} !== {1'b1, 5'd7, wd}) begin
                    n_fail++; $display("FAIL hps_strobe: got we=%b sel=%h data=%h want 1 07 %h", regwrite, regsel, regdata, wd);
                end
            end else begin
                n_cmp++; if ({ack, err} !== {4'b0010, 1'b0}) begin
                    n_fail++; $display("FAIL hps_ack: got ack=%b err=%b want 0010 0", ack, err);
                end
            end
        end
        req[1] = 1'b0;
        hps_write = 1'b0;
        ref_bank[7] = wd;
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL hps_pulses: got %0d want 1", pulses); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int pulses, ack_c;
        logic ack_err;
        pulses = 0;
        ack_c = -1;
        ack_err = 1'b0;
        @(negedge clk);
        set_req(3, 1'b1, 5'd9, $urandom);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            hps_write = 1'b1;
            #1;
            if (t_regwrite) pulses++;
            if (t_ack !== 4'b0 && ack_c < 0) begin
                ack_c = c;
                ack_err = t_err;
                n_cmp++; if (t_ack !== 4'b1000) begin n_fail++; $display("FAIL to_ack_id: got %b want 1000", t_ack); end
                req[3] = 1'b0;
            end
        end
        n_cmp++; if (ack_c != 5 || ack_err !== 1'b1) begin
            n_fail++; $display("FAIL to_ack: got cycle %0d err=%b want cycle 5 err=1", ack_c, ack_err);
        end
        n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL to_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_reset_mid();
        int t0;
        bit seen;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_stalled: got busy=%b want 1", busy); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if ({busy, ack, regwrite} !== 6'b0) begin
            n_fail++; $display("FAIL mid_reset: got busy=%b ack=%b we=%b want 0 0000 0", busy, ack, regwrite);
        end
        rst = 1'b0;
        hps_write = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, SW'(i + 10), 32'h0);
        t0 = cyc;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk); #1;
            if (ack !== 4'b0) begin
                seen = 1'b1;
                n_cmp++; if (ack !== 4'b0001 || cyc - t0 != 2 || rdata !== ref_bank[10]) begin
                    n_fail++; $display("FAIL mid_restart: got ack=%b at +%0d data=%h want 0001 at +2 data=%h",
                                       ack, cyc - t0, rdata, ref_bank[10]);
                end
                req = '0;
            end
        end
        req = '0;
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL mid_noack: got no ack want 0001"); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random_traffic();
        logic [NREQ-1:0]    snap_req, snap_we;
        logic [NREQ*SW-1:0] snap_sel;
        logic [NREQ*DW-1:0] snap_wd;
        logic [SW-1:0]      e_sel, p_sel;
        logic [DW-1:0]      e_wd, p_data;
        int last, prev_ack, nacks, start, pulses, p_cyc, exp_id, stalls;
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 1) == 1) set_req(i, 1'($urandom_range(0, 1)), SW'($urandom_range(0, 31)), $urandom);
        if (req == '0) set_req(0, 1'b1, SW'($urandom_range(0, 31)), $urandom);
        {snap_req, snap_we, snap_sel, snap_wd} = {req, req_we, req_sel, req_wdata};
        rst = 1'b0;
        prev_ack = cyc - 1;
        start = cyc;
        last = NREQ - 1;
        nacks = 0;
        pulses = 0;
        p_cyc = -1;
        p_sel = '0;
        p_data = '0;
        while (nacks < 60 && cyc - start < 1500) begin
            @(negedge clk);
            hps_write = ($urandom_range(0, 3) == 0);
            hps_hist[cyc & 4095] = hps_write;
            #1;
            if (regwrite) begin pulses++; p_sel = regsel; p_data = regdata; p_cyc = cyc; end
            if (ack !== 4'b0) begin
                exp_id = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (exp_id < 0 && snap_req[(last + k) % NREQ]) exp_id = (last + k) % NREQ;
                e_sel = snap_sel[exp_id*SW +: SW];
                e_wd = snap_wd[exp_id*DW +: DW];
                stalls = 0;
                if (snap_we[exp_id])
                    while (stalls < 300 && hps_hist[(prev_ack + 2 + stalls) & 4095]) stalls++;
                n_cmp++; if (ack !== (4'b1 << exp_id) || cyc != prev_ack + 3 + stalls || err !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_ack[%0d]: got ack=%b err=%b at %0d want %b err=0 at %0d",
                                       nacks, ack, err, cyc, 4'b1 << exp_id, prev_ack + 3 + stalls);
                end
                if (snap_we[exp_id]) begin
                    n_cmp++; if (pulses != 1 || p_sel !== e_sel || p_data !== e_wd || p_cyc != cyc - 1) begin
                        n_fail++; $display("FAIL rnd_write[%0d]: got %0d pulses sel=%h data=%h at %0d want 1 sel=%h data=%h at %0d",
                                           nacks, pulses, p_sel, p_data, p_cyc, e_sel, e_wd, cyc - 1);
                    end
                    ref_bank[e_sel] = e_wd;
                end else begin
                    n_cmp++; if (pulses != 0 || rdata !== ref_bank[e_sel]) begin
                        n_fail++; $display("FAIL rnd_read[%0d]: got %0d pulses data=%h want 0 pulses data=%h",
                                           nacks, pulses, rdata, ref_bank[e_sel]);
                    end
                end
                last = exp_id;
                prev_ack = cyc;
                pulses = 0;
                nacks++;
                for (int i = 0; i < NREQ; i++) begin
                    if (i == exp_id || !req[i]) begin
                        req[i] = 1'b0;
                        if ($urandom_range(0, 3) != 0)
                            set_req(i, 1'($urandom_range(0, 1)), SW'($urandom_range(0, 31)), $urandom);
                    end
                end
                if (req == '0) set_req($urandom_range(0, NREQ - 1), 1'b0, SW'($urandom_range(0, 31)), 32'h0);
                {snap_req, snap_we, snap_sel, snap_wd} = {req, req_we, req_sel, req_wdata};
            end
        end
        req = '0;
        hps_write = 1'b0;
        n_cmp++; if (nacks < 60) begin n_fail++; $display("FAIL rnd_budget: got %0d acks want 60", nacks); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_hps_collision();
        test_timeout();
        test_reset_mid();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
